id_ex: RTL

Pipeline register between decode (`id`) and execute (`ex`) with a valid/ready handshake. It captures the decoded operands and control fields for `ex` and holds them while `ex` is busy, for example during a multi-cycle divide. A taken jump from `ex` flushes it. On a load-use hazard it inserts a one-cycle bubble and counts stall cycles for performance monitoring.

---
 rtl/tinyriscv_pkg.sv | 50 +++++
 rtl/id_ex.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tinyriscv_pkg.sv
// Shared bus widths, opcode constants and the decode-to-execute payload type.
package tinyriscv_pkg;

    localparam int INST_W      = 32;
    localparam int INST_ADDR_W = 32;
    localparam int MEM_ADDR_W  = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int REG_W       = 32;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [6:0]        INST_TYPE_L = 7'b0000011;
    localparam logic [INST_W-1:0] INST_NOP    = 32'h0000_0013;

    // Everything decode hands to execute, in one bundle shared by both stages.
    typedef struct packed {
        logic [INST_W-1:0]      inst;
        logic [INST_ADDR_W-1:0] inst_addr;
        logic [MEM_ADDR_W-1:0]  op1;
        logic [MEM_ADDR_W-1:0]  op2;
        logic                   reg_we;
        logic [REG_ADDR_W-1:0]  reg_waddr;
        logic                   csr_we;
        logic [MEM_ADDR_W-1:0]  csr_waddr;
        logic [REG_W-1:0]       csr_rdata;
        logic [2:0]             compare;
        logic [REG_W-1:0]       store_data;
    } id_ex_payload_t;

    // What the register does on a clock edge, highest priority first.
    typedef enum logic [2:0] {
        ACT_FLUSH  = 3'd0,
        ACT_HOLD   = 3'd1,
        ACT_HAZARD = 3'd2,
        ACT_LOAD   = 3'd3,
        ACT_BUBBLE = 3'd4
    } id_ex_action_e;

    // A bubble is a NOP that writes nothing; execute only looks at its inst field.
    function automatic id_ex_payload_t bubble_payload();
        id_ex_payload_t p;
        p        = '0;
        p.inst   = INST_NOP;
        p.reg_we = WriteDisable;
        p.csr_we = WriteDisable;
        return p;
    endfunction

endpackage

// File: rtl/id_ex.sv
// Decode/execute pipeline register with valid/ready handshake, flush on taken
// jump, hold while execute is busy and a one-cycle bubble on load-use hazards.
module id_ex
    import tinyriscv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid_i,
    output logic                   id_ready_o,
    input  logic [INST_W-1:0]      inst_i,
    input  logic [INST_ADDR_W-1:0] inst_addr_i,
    input  logic [MEM_ADDR_W-1:0]  op1_i,
    input  logic [MEM_ADDR_W-1:0]  op2_i,
    input  logic                   reg_we_i,
    input  logic [REG_ADDR_W-1:0]  reg_waddr_i,
    input  logic [REG_ADDR_W-1:0]  reg1_raddr_i,
    input  logic [REG_ADDR_W-1:0]  reg2_raddr_i,
    input  logic                   csr_we_i,
    input  logic [MEM_ADDR_W-1:0]  csr_waddr_i,
    input  logic [REG_W-1:0]       csr_rdata_i,
    input  logic [2:0]             compare_i,
    input  logic [REG_W-1:0]       store_data_i,
    input  logic                   ex_busy_i,
    input  logic                   ex_jump_flag_i,
    output logic                   ex_valid_o,
    output logic [INST_W-1:0]      inst_o,
    output logic [INST_ADDR_W-1:0] inst_addr_o,
    output logic [MEM_ADDR_W-1:0]  op1_o,
    output logic [MEM_ADDR_W-1:0]  op2_o,
    output logic                   reg_we_o,
    output logic [REG_ADDR_W-1:0]  reg_waddr_o,
    output logic                   csr_we_o,
    output logic [MEM_ADDR_W-1:0]  csr_waddr_o,
    output logic [REG_W-1:0]       csr_rdata_o,
    output logic [2:0]             compare_o,
    output logic [REG_W-1:0]       store_data_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    id_ex_payload_t payload_r;
    logic           ex_valid_r;
    logic [CNT_W-1:0] stall_cnt_r;

    id_ex_payload_t id_payload_s;
    id_ex_payload_t payload_nxt_s;
    logic           ex_valid_nxt_s;
    logic [CNT_W-1:0] stall_cnt_nxt_s;
    logic           hz_s;
    id_ex_action_e  action_s;

    // Gather the decode-side fields into one payload record.
    always_comb begin
        id_payload_s            = '0;
        id_payload_s.inst       = inst_i;
        id_payload_s.inst_addr  = inst_addr_i;
        id_payload_s.op1        = op1_i;
        id_payload_s.op2        = op2_i;
        id_payload_s.reg_we     = reg_we_i;
        id_payload_s.reg_waddr  = reg_waddr_i;
        id_payload_s.csr_we     = csr_we_i;
        id_payload_s.csr_waddr  = csr_waddr_i;
        id_payload_s.csr_rdata  = csr_rdata_i;
        id_payload_s.compare    = compare_i;
        id_payload_s.store_data = store_data_i;
    end

    // Load-use hazard: execute holds a load to a real register that decode reads.
    always_comb begin
        hz_s = 1'b0;
        if (ex_valid_r && (payload_r.inst[6:0] == INST_TYPE_L) &&
            (payload_r.reg_we == WriteEnable) &&
            (payload_r.reg_waddr != {REG_ADDR_W{1'b0}}) && id_valid_i &&
            ((reg1_raddr_i == payload_r.reg_waddr) ||
             (reg2_raddr_i == payload_r.reg_waddr))) begin
            hz_s = 1'b1;
        end else begin
            hz_s = 1'b0;
        end
    end

    // Pick this edge's action; a flush overrides everything, including busy.
    always_comb begin
        action_s = ACT_BUBBLE;
        if (ex_jump_flag_i) begin
            action_s = ACT_FLUSH;
        end else if (ex_busy_i) begin
            action_s = ACT_HOLD;
        end else if (hz_s) begin
            action_s = ACT_HAZARD;
        end else if (id_valid_i) begin
            action_s = ACT_LOAD;
        end else begin
            action_s = ACT_BUBBLE;
        end
    end

    // Ready is combinational so decode can advance in the same cycle.
    always_comb begin
        id_ready_o = ex_jump_flag_i | (~ex_busy_i & ~hz_s);
    end

    // Next register contents and stall count for the selected action.
    always_comb begin
        payload_nxt_s   = bubble_payload();
        ex_valid_nxt_s  = 1'b0;
        stall_cnt_nxt_s = stall_cnt_r;
        case (action_s)
            ACT_FLUSH: begin
                payload_nxt_s  = bubble_payload();
                ex_valid_nxt_s = 1'b0;
            end
            ACT_HOLD: begin
                payload_nxt_s  = payload_r;
                ex_valid_nxt_s = ex_valid_r;
            end
            ACT_HAZARD: begin
                payload_nxt_s  = bubble_payload();
                ex_valid_nxt_s = 1'b0;
                if (stall_cnt_r != CNT_MAX) begin
                    stall_cnt_nxt_s = stall_cnt_r + CNT_ONE;
                end else begin
                    stall_cnt_nxt_s = stall_cnt_r;
                end
            end
            ACT_LOAD: begin
                payload_nxt_s  = id_payload_s;
                ex_valid_nxt_s = 1'b1;
            end
            ACT_BUBBLE: begin
                payload_nxt_s  = bubble_payload();
                ex_valid_nxt_s = 1'b0;
            end
            default: begin
                payload_nxt_s  = bubble_payload();
                ex_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Pipeline register bank and stall counter; reset leaves a bubble behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload_r   <= bubble_payload();
            ex_valid_r  <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            payload_r   <= payload_nxt_s;
            ex_valid_r  <= ex_valid_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
        end
    end

    assign ex_valid_o   = ex_valid_r;
    assign inst_o       = payload_r.inst;
    assign inst_addr_o  = payload_r.inst_addr;
    assign op1_o        = payload_r.op1;
    assign op2_o        = payload_r.op2;
    assign reg_we_o     = payload_r.reg_we;
    assign reg_waddr_o  = payload_r.reg_waddr;
    assign csr_we_o     = payload_r.csr_we;
    assign csr_waddr_o  = payload_r.csr_waddr;
    assign csr_rdata_o  = payload_r.csr_rdata;
    assign compare_o    = payload_r.compare;
    assign store_data_o = payload_r.store_data;
    assign stall_cnt_o  = stall_cnt_r;

endmodule
